// File: rtl/sequenceur_chute_pkg.sv
// Shared definitions for the TroisBriques drop sequencer: FSM states,
// column codes and the default board height.
package sequenceur_chute_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FALL,
        ST_LAND,
        ST_FULL
    } state_t;

    localparam logic [1:0] COL_GAUCHE = 2'd0;
    localparam logic [1:0] COL_CENTRE = 2'd1;
    localparam logic [1:0] COL_DROITE = 2'd2;
    localparam logic [1:0] COL_NONE   = 2'd3;

    localparam int ROWS_DEFAULT = 7;

endpackage

// File: rtl/sequenceur_chute.sv
// Drop sequencer: animates a brick falling one row per tick into the chosen
// column, updates that column's height and hands the turn to the other player.
module sequenceur_chute
    import sequenceur_chute_pkg::*;
#(
    parameter int ROWS = ROWS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       drop_req,
    input  logic [1:0] col_sel,
    output logic [2:0] hauteurGauche,
    output logic [2:0] hauteurCentre,
    output logic [2:0] hauteurDroite,
    output logic       falling,
    output logic [1:0] fall_col,
    output logic [2:0] fall_row,
    output logic       player,
    output logic       done,
    output logic       reject,
    output logic       board_full
);

    localparam logic [2:0] FULL_H  = 3'(ROWS);
    localparam logic [2:0] TOP_ROW = 3'(ROWS - 1);

    state_t     state;
    logic [2:0] height [3];
    logic [2:0] sel_height;
    logic [2:0] fall_height;
    logic       full_after_land;

    // An invalid column reads as full so one comparison covers both refusals.
    always_comb begin
        sel_height = FULL_H;
        case (col_sel)
            COL_GAUCHE: sel_height = height[0];
            COL_CENTRE: sel_height = height[1];
            COL_DROITE: sel_height = height[2];
            default:    sel_height = FULL_H;
        endcase
    end

    always_comb begin
        fall_height = '0;
        case (fall_col)
            COL_GAUCHE: fall_height = height[0];
            COL_CENTRE: fall_height = height[1];
            COL_DROITE: fall_height = height[2];
            default:    fall_height = '0;
        endcase
    end

    // Board is full after this landing if every column is full counting the brick about to land.
    always_comb begin
        full_after_land = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            if (!((height[i] == FULL_H) ||
                  ((fall_col == 2'(i)) && (height[i] == FULL_H - 3'd1))))
                full_after_land = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            for (int unsigned i = 0; i < 3; i++)
                height[i] <= '0;
            fall_col <= '0;
            fall_row <= '0;
            falling  <= 1'b0;
            player   <= 1'b0;
            done     <= 1'b0;
            reject   <= 1'b0;
        end else begin
            done   <= 1'b0;
            reject <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (drop_req) begin
                        if (sel_height == FULL_H) begin
                            reject <= 1'b1;
                        end else begin
                            fall_col <= col_sel;
                            fall_row <= TOP_ROW;
                            falling  <= 1'b1;
                            state    <= ST_FALL;
                        end
                    end
                end
                ST_FALL: begin
                    if (drop_req)
                        reject <= 1'b1;
                    if (tick) begin
                        if (fall_row == fall_height)
                            state <= ST_LAND;
                        else
                            fall_row <= fall_row - 3'd1;
                    end
                end
                ST_LAND: begin
                    if (drop_req)
                        reject <= 1'b1;
                    for (int unsigned i = 0; i < 3; i++) begin
                        if (fall_col == 2'(i))
                            height[i] <= height[i] + 3'd1;
                    end
                    done    <= 1'b1;
                    player  <= ~player;
                    falling <= 1'b0;
                    state   <= full_after_land ? ST_FULL : ST_IDLE;
                end
                ST_FULL: begin
                    if (drop_req)
                        reject <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign hauteurGauche = height[0];
    assign hauteurCentre = height[1];
    assign hauteurDroite = height[2];
    assign board_full    = (state == ST_FULL);

endmodule

// File: tb/tb_sequenceur_chute.sv
// Directed bench for sequenceur_chute: a table of drops with expected heights,
// landing latency and player, plus hand-written multi-cycle corner cases.
module tb_sequenceur_chute;

    localparam int ROWS = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       drop_req;
    logic [1:0] col_sel;
    logic [2:0] hauteurGauche, hauteurCentre, hauteurDroite;
    logic       falling;
    logic [1:0] fall_col;
    logic [2:0] fall_row;
    logic       player, done, reject, board_full;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] col;
        logic       rej;
        int         ticks;
        logic [2:0] g, c, d;
        logic       pl;
    } vec_t;

    vec_t vecs [21];

    sequenceur_chute #(.ROWS(ROWS)) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .drop_req      (drop_req),
        .col_sel       (col_sel),
        .hauteurGauche (hauteurGauche),
        .hauteurCentre (hauteurCentre),
        .hauteurDroite (hauteurDroite),
        .falling       (falling),
        .fall_col      (fall_col),
        .fall_row      (fall_row),
        .player        (player),
        .done          (done),
        .reject        (reject),
        .board_full    (board_full)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_drop(input logic [1:0] col);
        @(negedge clk);
        drop_req = 1'b1;
        col_sel  = col;
        @(negedge clk);
        drop_req = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Tick until done appears one cycle after a tick; row checked while still falling.
    task automatic run_ticks(input string tag, input int exp_ticks, input int first_row, input int gap);
        int landed;
        landed = 0;
        for (int n = 1; n <= 10 && landed == 0; n++) begin
            repeat (gap) @(negedge clk);
            pulse_tick();
            if (n < exp_ticks)
                check({tag, " row"}, fall_row, first_row - n);
            check({tag, " early done"}, done, 0);
            @(negedge clk);
            if (done)
                landed = n;
        end
        check({tag, " ticks to land"}, landed, exp_ticks);
        check({tag, " falling after land"}, falling, 0);
    endtask

    task automatic check_board(input string tag, input int g, input int c, input int d, input int pl);
        check({tag, " hauteurGauche"}, hauteurGauche, g);
        check({tag, " hauteurCentre"}, hauteurCentre, c);
        check({tag, " hauteurDroite"}, hauteurDroite, d);
        check({tag, " player"}, player, pl);
    endtask

    task automatic apply_vec(input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        pulse_drop(vecs[idx].col);
        if (vecs[idx].rej) begin
            check({tag, " reject"}, reject, 1);
            check({tag, " falling"}, falling, 0);
            @(negedge clk);
            check({tag, " reject width"}, reject, 0);
        end else begin
            check({tag, " reject"}, reject, 0);
            check({tag, " falling"}, falling, 1);
            check({tag, " fall_col"}, fall_col, vecs[idx].col);
            check({tag, " fall_row"}, fall_row, ROWS - 1);
            run_ticks(tag, vecs[idx].ticks, ROWS - 1, 1);
        end
        check_board(tag, vecs[idx].g, vecs[idx].c, vecs[idx].d, vecs[idx].pl);
    endtask

    initial begin
        vecs[0]  = '{2'd0, 1'b0, 7, 3'd1, 3'd1, 3'd0, 1'b0};
        vecs[1]  = '{2'd0, 1'b0, 6, 3'd2, 3'd1, 3'd0, 1'b1};
        vecs[2]  = '{2'd0, 1'b0, 5, 3'd3, 3'd1, 3'd0, 1'b0};
        vecs[3]  = '{2'd0, 1'b0, 4, 3'd4, 3'd1, 3'd0, 1'b1};
        vecs[4]  = '{2'd0, 1'b0, 3, 3'd5, 3'd1, 3'd0, 1'b0};
        vecs[5]  = '{2'd0, 1'b0, 2, 3'd6, 3'd1, 3'd0, 1'b1};
        vecs[6]  = '{2'd0, 1'b0, 1, 3'd7, 3'd1, 3'd0, 1'b0};
        vecs[7]  = '{2'd0, 1'b1, 0, 3'd7, 3'd1, 3'd0, 1'b0};
        vecs[8]  = '{2'd3, 1'b1, 0, 3'd7, 3'd1, 3'd0, 1'b0};
        vecs[9]  = '{2'd2, 1'b0, 6, 3'd7, 3'd1, 3'd2, 1'b0};
        vecs[10] = '{2'd2, 1'b0, 5, 3'd7, 3'd1, 3'd3, 1'b1};
        vecs[11] = '{2'd2, 1'b0, 4, 3'd7, 3'd1, 3'd4, 1'b0};
        vecs[12] = '{2'd2, 1'b0, 3, 3'd7, 3'd1, 3'd5, 1'b1};
        vecs[13] = '{2'd2, 1'b0, 1, 3'd7, 3'd1, 3'd7, 1'b1};
        vecs[14] = '{2'd2, 1'b1, 0, 3'd7, 3'd1, 3'd7, 1'b1};
        vecs[15] = '{2'd1, 1'b0, 6, 3'd7, 3'd2, 3'd7, 1'b0};
        vecs[16] = '{2'd1, 1'b0, 5, 3'd7, 3'd3, 3'd7, 1'b1};
        vecs[17] = '{2'd1, 1'b0, 4, 3'd7, 3'd4, 3'd7, 1'b0};
        vecs[18] = '{2'd1, 1'b0, 3, 3'd7, 3'd5, 3'd7, 1'b1};
        vecs[19] = '{2'd1, 1'b0, 2, 3'd7, 3'd6, 3'd7, 1'b0};
        vecs[20] = '{2'd1, 1'b0, 1, 3'd7, 3'd7, 3'd7, 1'b1};

        reset    = 1'b1;
        tick     = 1'b0;
        drop_req = 1'b0;
        col_sel  = 2'd0;
        repeat (3) @(negedge clk);
        check_board("reset", 0, 0, 0, 0);
        check("reset falling", falling, 0);
        check("reset fall_col", fall_col, 0);
        check("reset fall_row", fall_row, 0);
        check("reset done", done, 0);
        check("reset reject", reject, 0);
        check("reset board_full", board_full, 0);
        reset = 1'b0;

        // First drop on the centre column with slow ticks.
        pulse_drop(2'd1);
        check("t1 falling", falling, 1);
        check("t1 fall_col", fall_col, 1);
        check("t1 fall_row", fall_row, 6);
        run_ticks("t1", 7, 6, 50);
        check_board("t1", 0, 1, 0, 1);

        for (int i = 0; i <= 8; i++)
            apply_vec(i);

        // Drop request while a brick is falling is refused without disturbing it.
        pulse_drop(2'd2);
        pulse_tick();
        pulse_tick();
        check("t3 row before", fall_row, 4);
        pulse_drop(2'd1);
        check("t3 reject", reject, 1);
        check("t3 falling", falling, 1);
        check("t3 fall_col", fall_col, 2);
        check("t3 fall_row", fall_row, 4);
        run_ticks("t3", 5, 4, 1);
        check_board("t3", 7, 1, 1, 1);

        for (int i = 9; i <= 12; i++)
            apply_vec(i);

        // Tick coinciding with the accepted drop must not advance the row.
        @(negedge clk);
        drop_req = 1'b1;
        tick     = 1'b1;
        col_sel  = 2'd2;
        @(negedge clk);
        drop_req = 1'b0;
        tick     = 1'b0;
        check("t6 falling", falling, 1);
        check("t6 fall_row", fall_row, 6);
        run_ticks("t6", 2, 6, 1);
        check_board("t6", 7, 1, 6, 0);

        for (int i = 13; i <= 20; i++)
            apply_vec(i);
        check("t4 board_full", board_full, 1);
        pulse_drop(2'd0);
        check("t4 reject full", reject, 1);
        check("t4 falling full", falling, 0);
        check_board("t4 after reject", 7, 7, 7, 1);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_board("t4 cleared", 0, 0, 0, 0);
        check("t4 board_full cleared", board_full, 0);

        // Asynchronous reset in the middle of a fall.
        pulse_drop(2'd0);
        pulse_tick();
        pulse_tick();
        pulse_tick();
        check("t5 row", fall_row, 3);
        #2;
        reset = 1'b1;
        #1;
        check("t5 falling", falling, 0);
        check_board("t5", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5 no done", done, 0);
        end
        check_board("t5 after", 0, 0, 0, 0);
        check("t5 falling after", falling, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
